// File: rtl/pa2se_tx.sv
`default_nettype none
// ============================================================================
// Module   : pa2se_tx
// Brief    : Serializes one 8-lane complex frame into an 8-beat AXI-Stream.
//            Define PA2SE_DBUF_EN to add a shadow buffer for gapless frames.
// Revision : 1.0
// ============================================================================
module pa2se_tx #(
  parameter int N_LANES = 8,
  parameter int DW      = 20,
  parameter int TDW     = 48
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_LANES-1:0][DW-1:0]   tx_sig_real,
  input  logic [N_LANES-1:0][DW-1:0]   tx_sig_imag,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [TDW-1:0]               fft_s_data_tdata,
  output logic [$clog2(N_LANES)-1:0]   fft_s_data_tuser,
  output logic                         fft_s_data_tvalid,
  output logic                         fft_s_data_tlast,
  input  logic                         fft_s_data_tready,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int            IW       = $clog2(N_LANES);
  localparam int            HW       = TDW / 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_LANES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  typedef logic [N_LANES-1:0][DW-1:0] lanes_t;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_nxt;
  lanes_t         act_re;
  lanes_t         act_im;
  lanes_t         act_re_nxt;
  lanes_t         act_im_nxt;
  logic           accept;
  logic           beat_hs;
  logic           last_hs;
  logic           load_in;

  logic [TDW-1:0] tdata_nxt;
  logic [IW-1:0]  tuser_nxt;
  logic           tvalid_nxt;
  logic           tlast_nxt;

  function automatic logic [HW-1:0] sext(input logic [DW-1:0] v);
    return {{(HW-DW){v[DW-1]}}, v};
  endfunction

`ifdef PA2SE_DBUF_EN
  lanes_t sh_re;
  lanes_t sh_im;
  logic   shadow_full;
  logic   shadow_full_nxt;
  logic   load_sh;
  logic   store_sh;

  assign tx_ready = !shadow_full;
`else
  assign tx_ready = (state == S_IDLE);
`endif

  assign accept  = tx_valid && tx_ready;
  assign beat_hs = fft_s_data_tvalid && fft_s_data_tready;
  assign last_hs = beat_hs && (idx == LAST_IDX);
  assign busy    = (state == S_SEND);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_in   = 1'b0;
`ifdef PA2SE_DBUF_EN
    load_sh         = 1'b0;
    store_sh        = 1'b0;
    shadow_full_nxt = shadow_full;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          load_in   = 1'b1;
          idx_nxt   = '0;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (last_hs) begin
          idx_nxt = '0;
`ifdef PA2SE_DBUF_EN
          // tx_ready is low while the shadow is full, so accept and
          // shadow_full are mutually exclusive here.
          if (shadow_full) begin
            load_sh         = 1'b1;
            shadow_full_nxt = 1'b0;
          end else if (accept) begin
            load_in = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
`else
          state_nxt = S_IDLE;
`endif
        end else if (beat_hs) begin
          idx_nxt = idx + 1'b1;
        end
`ifdef PA2SE_DBUF_EN
        if (accept && !last_hs) begin
          store_sh        = 1'b1;
          shadow_full_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    act_re_nxt = act_re;
    act_im_nxt = act_im;
    if (load_in) begin
      act_re_nxt = tx_sig_real;
      act_im_nxt = tx_sig_imag;
    end
`ifdef PA2SE_DBUF_EN
    else if (load_sh) begin
      act_re_nxt = sh_re;
      act_im_nxt = sh_im;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_re <= '0;
      act_im <= '0;
    end else begin
      act_re <= act_re_nxt;
      act_im <= act_im_nxt;
    end
  end

`ifdef PA2SE_DBUF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_re       <= '0;
      sh_im       <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (store_sh) begin
        sh_re <= tx_sig_real;
        sh_im <= tx_sig_imag;
      end
      shadow_full <= shadow_full_nxt;
    end
  end
`endif

  // Beat outputs are built from next-cycle state so beat 0 is registered
  // on the same edge that accepts the frame.
  always_comb begin
    tvalid_nxt = (state_nxt == S_SEND);
    tuser_nxt  = '0;
    tlast_nxt  = 1'b0;
    tdata_nxt  = '0;
    if (state_nxt == S_SEND) begin
      tuser_nxt = idx_nxt;
      tlast_nxt = (idx_nxt == LAST_IDX);
      tdata_nxt = {sext(act_im_nxt[idx_nxt]), sext(act_re_nxt[idx_nxt])};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fft_s_data_tdata  <= '0;
      fft_s_data_tuser  <= '0;
      fft_s_data_tvalid <= 1'b0;
      fft_s_data_tlast  <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      fft_s_data_tdata  <= tdata_nxt;
      fft_s_data_tuser  <= tuser_nxt;
      fft_s_data_tvalid <= tvalid_nxt;
      fft_s_data_tlast  <= tlast_nxt;
      frame_done        <= last_hs;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pa2se_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pa2se_tx
// Brief    : Bench for pa2se_tx; beat-queue reference model plus directed
//            cases. Honors PA2SE_DBUF_EN.
// Revision : 1.0
// ============================================================================
module tb_pa2se_tx;

  localparam int NL  = 8;
  localparam int DW  = 20;
  localparam int TDW = 48;
`ifdef PA2SE_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef logic [NL-1:0][DW-1:0] lanes_t;
  typedef struct packed {
    logic [TDW-1:0] d;
    logic [2:0]     u;
    logic           l;
  } beat_t;

  logic           clk         = 1'b0;
  logic           rstn        = 1'b0;
  lanes_t         tx_sig_real = '0;
  lanes_t         tx_sig_imag = '0;
  logic           tx_valid    = 1'b0;
  logic           tx_ready;
  logic [TDW-1:0] fft_s_data_tdata;
  logic [2:0]     fft_s_data_tuser;
  logic           fft_s_data_tvalid;
  logic           fft_s_data_tlast;
  logic           fft_s_data_tready;
  logic           frame_done;
  logic           busy;

  logic rdy_rand   = 1'b0;
  logic rdy_manual = 1'b1;
  logic rnd_bit    = 1'b1;

  int    total  = 0;
  int    bad    = 0;
  int    hs_cnt = 0;
  beat_t exp_q[$];
  logic  fd_exp = 1'b0;

  pa2se_tx dut (
    .clk               (clk),
    .rstn              (rstn),
    .tx_sig_real       (tx_sig_real),
    .tx_sig_imag       (tx_sig_imag),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .fft_s_data_tdata  (fft_s_data_tdata),
    .fft_s_data_tuser  (fft_s_data_tuser),
    .fft_s_data_tvalid (fft_s_data_tvalid),
    .fft_s_data_tlast  (fft_s_data_tlast),
    .fft_s_data_tready (fft_s_data_tready),
    .frame_done        (frame_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  assign fft_s_data_tready = rdy_rand ? rnd_bit : rdy_manual;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected beats of a frame: lane k on beat k, components sign-extended to 24 bits.
  task automatic push_frame(input lanes_t re, input lanes_t im);
    for (int k = 0; k < NL; k++) begin
      beat_t b;
      logic signed [23:0] r24;
      logic signed [23:0] i24;
      r24 = $signed(re[k]);
      i24 = $signed(im[k]);
      b.d = {i24, r24};
      b.u = 3'(k);
      b.l = (k == NL - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic lanes_t rnd_lanes();
    lanes_t v;
    for (int k = 0; k < NL; k++) begin
      case ($urandom_range(0, 7))
        0:       v[k] = 20'h80000;
        1:       v[k] = 20'h7FFFF;
        default: v[k] = 20'($urandom);
      endcase
    end
    return v;
  endfunction

  // Reference model: beats still owed form a queue; whole frames in flight
  // determine tx_ready, a non-empty queue means tvalid/busy.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      fd_exp = 1'b0;
    end else begin
      int    nfr;
      beat_t b;
      nfr = (exp_q.size() + NL - 1) / NL;
      check_eq("frame_done", 64'(frame_done), 64'(fd_exp));
      check_eq("tvalid", 64'(fft_s_data_tvalid), 64'(exp_q.size() != 0));
      check_eq("busy", 64'(busy), 64'(exp_q.size() != 0));
      check_eq("tx_ready", 64'(tx_ready), DBUF ? 64'(nfr < 2) : 64'(nfr == 0));
      fd_exp = 1'b0;
      if (fft_s_data_tvalid && exp_q.size() != 0) begin
        b = exp_q[0];
        check_eq("tdata", 64'(fft_s_data_tdata), 64'(b.d));
        check_eq("tuser", 64'(fft_s_data_tuser), 64'(b.u));
        check_eq("tlast", 64'(fft_s_data_tlast), 64'(b.l));
        if (fft_s_data_tready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
          fd_exp = b.l;
        end
      end
      if (tx_valid && tx_ready) push_frame(tx_sig_real, tx_sig_imag);
    end
  end

  // Entered and left at posedge+1; inputs are scrambled right after accept.
  task automatic send_frame(input lanes_t re, input lanes_t im);
    int n;
    n           = 0;
    tx_sig_real = re;
    tx_sig_imag = im;
    tx_valid    = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check_eq("send_timeout", 64'(tx_ready), 64'(1));
    @(posedge clk);
    #1;
    tx_valid    = 1'b0;
    tx_sig_real = rnd_lanes();
    tx_sig_imag = rnd_lanes();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    lanes_t re;
    lanes_t im;
    int     h0;
    int     beats;
    int     gaps;
    int     n;
    bit     started;

    // Reset values
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_tvalid", 64'(fft_s_data_tvalid), 64'(0));
    check_eq("rst_tdata", 64'(fft_s_data_tdata), 64'(0));
    check_eq("rst_tuser", 64'(fft_s_data_tuser), 64'(0));
    check_eq("rst_tlast", 64'(fft_s_data_tlast), 64'(0));
    check_eq("rst_done", 64'(frame_done), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single frame with ramp data, cycle-exact beat timing
    for (int k = 0; k < NL; k++) begin
      re[k] = 20'(k + 1);
      im[k] = 20'(-(k + 1));
    end
    send_frame(re, im);
    #4;
    for (int c = 1; c <= NL; c++) begin
      check_eq("t2_tvalid", 64'(fft_s_data_tvalid), 64'(1));
      check_eq("t2_tuser", 64'(fft_s_data_tuser), 64'(c - 1));
      check_eq("t2_tlast", 64'(fft_s_data_tlast), 64'(c == NL));
      if (c == 3) check_eq("t2_beat2", 64'(fft_s_data_tdata), 64'(48'hFFFFFD_000003));
      @(negedge clk);
    end
    check_eq("t2_done", 64'(frame_done), 64'(1));
    wait_idle();

    // Sign extension at the extremes
    re    = rnd_lanes();
    im    = rnd_lanes();
    re[0] = 20'h80000;
    im[0] = 20'h7FFFF;
    send_frame(re, im);
    #4;
    check_eq("t3_sext", 64'(fft_s_data_tdata), 64'(48'h07FFFF_F80000));
    wait_idle();

    // Backpressure for 5 cycles while beat 4 is presented
    h0 = hs_cnt;
    send_frame(rnd_lanes(), rnd_lanes());
    repeat (4) @(posedge clk);
    #1;
    rdy_manual = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("t4_hold_tuser", 64'(fft_s_data_tuser), 64'(4));
      check_eq("t4_hold_tvalid", 64'(fft_s_data_tvalid), 64'(1));
    end
    @(posedge clk);
    #1;
    rdy_manual = 1'b1;
    wait_idle();
    check_eq("t4_beats", 64'(hs_cnt - h0), 64'(8));

    // Three frames back-to-back with tx_valid held
    beats   = 0;
    gaps    = 0;
    started = 1'b0;
    n       = 0;
    fork
      begin
        repeat (3) send_frame(rnd_lanes(), rnd_lanes());
      end
      begin
        while (beats < 24 && n < 100) begin
          @(negedge clk);
          n++;
          if (fft_s_data_tvalid && fft_s_data_tready) begin
            beats++;
            started = 1'b1;
          end else if (started && !fft_s_data_tvalid) begin
            gaps++;
          end
        end
      end
    join
    check_eq("t5_beats", 64'(beats), 64'(24));
    check_eq("t5_gaps", 64'(gaps), DBUF ? 64'(0) : 64'(2));
    wait_idle();

    // Third frame must see tx_ready low while two are in flight
    send_frame(rnd_lanes(), rnd_lanes());
    send_frame(rnd_lanes(), rnd_lanes());
    fork
      send_frame(rnd_lanes(), rnd_lanes());
      begin
        @(negedge clk);
        check_eq("t6_ready_blocked", 64'(tx_ready), 64'(0));
      end
    join
    wait_idle();

    // Random frames, gaps and backpressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 50; f++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send_frame(rnd_lanes(), rnd_lanes());
    end
    wait_idle();
    rdy_rand   = 1'b0;
    rdy_manual = 1'b1;

    // Asynchronous reset while beat 3 is presented
    send_frame(rnd_lanes(), rnd_lanes());
    repeat (3) @(posedge clk);
    #2;
    check_eq("t1_pre_tuser", 64'(fft_s_data_tuser), 64'(3));
    #1;
    rstn = 1'b0;
    #1;
    check_eq("t1_tvalid", 64'(fft_s_data_tvalid), 64'(0));
    check_eq("t1_tdata", 64'(fft_s_data_tdata), 64'(0));
    check_eq("t1_tuser", 64'(fft_s_data_tuser), 64'(0));
    check_eq("t1_tlast", 64'(fft_s_data_tlast), 64'(0));
    check_eq("t1_done", 64'(frame_done), 64'(0));
    check_eq("t1_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_eq("t1_rel_ready", 64'(tx_ready), 64'(1));
    check_eq("t1_rel_tvalid", 64'(fft_s_data_tvalid), 64'(0));
    repeat (5) @(negedge clk);
    check_eq("t1_no_stray", 64'(fft_s_data_tvalid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
